// File: rtl/mul_mc_sequencer.sv
// Issue/collect sequencer for a multicycle multiplier: latches operands, holds them stable,
// and returns the product on done, on the unchanged-operand shortcut, or on timeout (with error).
module mul_mc_sequencer #(
  parameter int W       = 64,
  parameter int TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_y,
  output logic           out_err,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  input  logic [2*W-1:0] mul_y,
  input  logic           mul_done
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SAME = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  logic [1:0]     r_state;
  logic [CW-1:0]  r_wait_cnt;
  logic           r_in_ready;
  logic           r_out_valid;
  logic           r_out_err;
  logic [2*W-1:0] r_out_y;
  logic [W-1:0]   r_mul_a;
  logic [W-1:0]   r_mul_b;

  logic w_accept;
  logic w_same_ops;
  logic w_done_ok;
  logic w_timeout;

  assign w_accept   = in_valid && r_in_ready;
  assign w_same_ops = (in_a == r_mul_a) && (in_b == r_mul_b);
  // A done pulse in the load cycle may belong to the previous operands, so it is not trusted.
  assign w_done_ok  = mul_done && (r_wait_cnt != '0);
  assign w_timeout  = (r_wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_wait_cnt  <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_err   <= 1'b0;
      r_out_y     <= '0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_mul_a    <= in_a;
            r_mul_b    <= in_b;
            r_in_ready <= 1'b0;
            if (w_same_ops) begin
              r_state <= ST_SAME;
            end else begin
              r_state    <= ST_WAIT;
              r_wait_cnt <= '0;
            end
          end
        end
        // Unchanged operands never produce a done pulse; the registered product is already valid.
        ST_SAME: begin
          r_out_y     <= mul_y;
          r_out_valid <= 1'b1;
          r_out_err   <= 1'b0;
          r_state     <= ST_RESP;
        end
        ST_WAIT: begin
          r_wait_cnt <= r_wait_cnt + CW'(1);
          if (w_done_ok) begin
            r_out_y     <= mul_y;
            r_out_valid <= 1'b1;
            r_out_err   <= 1'b0;
            r_state     <= ST_RESP;
          end else if (w_timeout) begin
            r_out_y     <= mul_y;
            r_out_valid <= 1'b1;
            r_out_err   <= 1'b1;
            r_state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_err   <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_err   = r_out_err;
  assign out_y     = r_out_y;
  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;

endmodule
